// File: rtl/smart_bus_drain_if.sv
// Bundle of the drain engine's control, row-bus and downstream stream signals.
// slave = drain engine side, master = controller / row / consumer side.
interface smart_bus_drain_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_COLS  = 4
);
  localparam int COL_W = $clog2(NUM_COLS);

  logic                 start_in;
  logic                 busy_out;
  logic                 done_out;
  logic [NUM_COLS-1:0]  select_right_out_smart;
  logic [WORD_SIZE-1:0] horizontal_smart_bus_in;
  logic [WORD_SIZE-1:0] data_out;
  logic [COL_W-1:0]     col_idx_out;
  logic                 data_valid_out;
  logic                 data_ready_in;
  logic [15:0]          stall_cnt_out;
  logic [1:0]           state_out;

  modport slave (
    input  start_in, horizontal_smart_bus_in, data_ready_in,
    output busy_out, done_out, select_right_out_smart, data_out, col_idx_out,
           data_valid_out, stall_cnt_out, state_out
  );

  modport master (
    output start_in, horizontal_smart_bus_in, data_ready_in,
    input  busy_out, done_out, select_right_out_smart, data_out, col_idx_out,
           data_valid_out, stall_cnt_out, state_out
  );
endinterface

// File: rtl/smart_bus_drain.sv
// Edge-of-row drain: selects each MAC column in turn, captures the bus into a FIFO
// and streams {col, word} downstream. SMART_DRAIN_STALL_CNT_EN enables the stall counter.
module smart_bus_drain #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_COLS   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  smart_bus_drain_if.slave bus
);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = COL_W + WORD_SIZE;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2} state_t;

  state_t               r_state, w_state_next;
  logic [COL_W-1:0]     r_col_cnt;
  logic                 w_last_col, w_full, w_empty, w_push, w_pop, w_start_ok;
  logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
  logic [CNT_W-1:0]     r_count, w_count_next;
  logic [ENT_W-1:0]     r_head, w_push_word;
  logic                 w_busy, w_done;
  logic [NUM_COLS-1:0]  w_select;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = (r_state == S_DRAIN) && !w_full;
  // Downstream handshake: a word transfers on any edge where data_valid_out and
  // data_ready_in are both high; data_out/col_idx_out never change while valid & !ready.
  assign w_pop       = !w_empty && bus.data_ready_in;
  assign w_last_col  = (r_col_cnt == COL_W'(NUM_COLS - 1));
  assign w_start_ok  = (r_state == S_IDLE) && bus.start_in;
  assign w_push_word = {r_col_cnt, bus.horizontal_smart_bus_in};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_in) w_state_next = S_DRAIN;
      S_DRAIN: if (w_push && w_last_col) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_select = '0;
    case (r_state)
      S_DRAIN: begin
        w_busy   = 1'b1;
        w_select = NUM_COLS'(1) << r_col_cnt;
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Column only advances on an accepted push, so a stall holds the same MAC selected.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) r_col_cnt <= '0;
    else if (w_push)       r_col_cnt <= w_last_col ? '0 : r_col_cnt + COL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_word;
  end

  assign w_rd_ptr_next = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
    end
  end

  // Head register: bypass the incoming word when it becomes the new head; hold when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
    end else if (w_count_next != '0) begin
      r_head <= (w_push && (r_wr_ptr == w_rd_ptr_next)) ? w_push_word : r_mem[w_rd_ptr_next];
    end
  end

`ifdef SMART_DRAIN_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_DRAIN) && w_full && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt_out = r_stall_cnt;
`else
  assign bus.stall_cnt_out = 16'd0;
`endif

  assign bus.busy_out               = w_busy;
  assign bus.done_out               = w_done;
  assign bus.select_right_out_smart = w_select;
  assign bus.data_out               = r_head[WORD_SIZE-1:0];
  assign bus.col_idx_out            = r_head[ENT_W-1:WORD_SIZE];
  assign bus.data_valid_out         = !w_empty;
  assign bus.state_out              = r_state;
endmodule

// File: tb/tb_smart_bus_drain.sv
// Bench for smart_bus_drain: directed passes against a modelled row bus, with an
// expected-word queue drained by a monitor on every downstream transfer.
module tb_smart_bus_drain;
  localparam int WS    = 16;
  localparam int NC    = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(NC);
  localparam int EW    = CW + WS;
  localparam int HOLD  = 5;
`ifdef SMART_DRAIN_STALL_CNT_EN
  localparam int EXP_STALL = HOLD + 1;
`else
  localparam int EXP_STALL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  smart_bus_drain_if #(.WORD_SIZE(WS), .NUM_COLS(NC)) u_if ();
  smart_bus_drain #(.WORD_SIZE(WS), .NUM_COLS(NC), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // Row model: the selected MAC i drives bus_base + i, nothing selected drives 0.
  logic [WS-1:0] bus_base = '0;
  always_comb begin
    u_if.horizontal_smart_bus_in = '0;
    for (int i = 0; i < NC; i++)
      if (u_if.select_right_out_smart[i]) u_if.horizontal_smart_bus_in = bus_base + WS'(i);
  end

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int exp_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: bus select legality, done pulses, and scoreboard pops on each transfer.
  always @(negedge clk) begin
    logic [EW-1:0] exp_w;
    if (!rst) begin
      check("sel_onehot0", 32'($onehot0(u_if.select_right_out_smart)), 32'd1);
      if (u_if.done_out) done_seen++;
      if (u_if.data_valid_out && u_if.data_ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", {u_if.col_idx_out, u_if.data_out});
        end else begin
          exp_w = exp_q.pop_front();
          check("drain_word", 32'({u_if.col_idx_out, u_if.data_out}), 32'(exp_w));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pass(input logic [WS-1:0] base);
    bus_base = base;
    for (int i = 0; i < NC; i++) exp_q.push_back({CW'(i), base + WS'(i)});
    exp_done++;
  endtask

  task automatic run_pass(input logic [WS-1:0] base, input bit poke);
    expect_pass(base);
    u_if.start_in = 1'b1;
    tick();
    for (int i = 0; i < NC; i++) begin
      u_if.start_in = poke && (i == 1);
      @(negedge clk);
      check("sel_drain", 32'(u_if.select_right_out_smart), 32'(1 << i));
      check("busy_drain", 32'(u_if.busy_out), 32'd1);
      tick();
    end
    u_if.start_in = poke;
    @(negedge clk);
    check("done_pulse", 32'(u_if.done_out), 32'd1);
    check("busy_done", 32'(u_if.busy_out), 32'd0);
    check("sel_done", 32'(u_if.select_right_out_smart), 32'd0);
    tick();
    u_if.start_in = 1'b0;
  endtask

  task automatic stall_pass(input logic [WS-1:0] base);
    expect_pass(base);
    u_if.data_ready_in = 1'b0;
    u_if.start_in = 1'b1;
    tick();
    u_if.start_in = 1'b0;
    @(negedge clk); check("stall_sel0", 32'(u_if.select_right_out_smart), 32'h1); tick();
    @(negedge clk); check("stall_sel1", 32'(u_if.select_right_out_smart), 32'h2); tick();
    for (int k = 0; k < HOLD; k++) begin
      @(negedge clk);
      check("stall_sel_hold", 32'(u_if.select_right_out_smart), 32'h4);
      check("head_stable", 32'({u_if.col_idx_out, u_if.data_out}), 32'({CW'(0), base}));
      check("valid_hold", 32'(u_if.data_valid_out), 32'd1);
      tick();
    end
    u_if.data_ready_in = 1'b1;
    @(negedge clk); check("sel_stall_pop", 32'(u_if.select_right_out_smart), 32'h4); tick();
    @(negedge clk); check("sel_col2_push", 32'(u_if.select_right_out_smart), 32'h4); tick();
    @(negedge clk); check("sel_col3", 32'(u_if.select_right_out_smart), 32'h8); tick();
    @(negedge clk); check("stall_done", 32'(u_if.done_out), 32'd1); tick();
    @(negedge clk); check("stall_cnt", 32'(u_if.stall_cnt_out), 32'(EXP_STALL)); tick();
  endtask

  task automatic reset_mid_pass();
    bus_base = 16'h4000;
    u_if.start_in = 1'b1;
    tick();
    u_if.start_in = 1'b0;
    @(negedge clk); check("rst_pass_sel0", 32'(u_if.select_right_out_smart), 32'h1); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_sel", 32'(u_if.select_right_out_smart), 32'd0);
    check("rst_valid", 32'(u_if.data_valid_out), 32'd0);
    check("rst_busy", 32'(u_if.busy_out), 32'd0);
    check("rst_done", 32'(u_if.done_out), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.start_in = 1'b0;
    u_if.data_ready_in = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_sel", 32'(u_if.select_right_out_smart), 32'd0);
    check("reset_busy", 32'(u_if.busy_out), 32'd0);
    check("reset_done", 32'(u_if.done_out), 32'd0);
    check("reset_valid", 32'(u_if.data_valid_out), 32'd0);
    check("reset_data", 32'(u_if.data_out), 32'd0);
    check("reset_col", 32'(u_if.col_idx_out), 32'd0);
    check("reset_stall", 32'(u_if.stall_cnt_out), 32'd0);
    check("reset_state", 32'(u_if.state_out), 32'd0);
    tick();

    run_pass(16'h00A0, 1'b0);
    @(negedge clk); check("idle_after_pass", 32'(u_if.busy_out), 32'd0); tick();

    stall_pass(16'h1230);

    run_pass(16'h3300, 1'b1);
    @(negedge clk);
    check("ignored_start_busy", 32'(u_if.busy_out), 32'd0);
    check("ignored_start_sel", 32'(u_if.select_right_out_smart), 32'd0);
    tick();

    reset_mid_pass();
    run_pass(16'h4400, 1'b0);

    run_pass(16'h5500, 1'b0);
    run_pass(16'h6600, 1'b0);
    @(negedge clk); check("stall_cleared", 32'(u_if.stall_cnt_out), 32'd0); tick();

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(exp_done));
    check("final_valid", 32'(u_if.data_valid_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
